mem_access_unit: RTL

- Load/store sequencer between the CPU datapath and the 256-word data memory. It sits directly upstream of the memory.
- Accepts byte, halfword and word load/store requests at byte addresses and checks alignment and range.
- Performs read-modify-write for sub-word stores, since the memory only writes whole words.
- Returns sign- or zero-extended load data with a ready handshake.

---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide data memory.
// Sub-word stores use a read-modify-write; loads return extended data.
module mem_access_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic        memoryWrite,
    output logic        memoryRead,
    output logic [31:0] memoryWriteData,
    output logic [31:0] memoryAddress,
    input  logic [31:0] memoryOutData
);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;

    logic        bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign bad = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (addr >= LIMIT);

    // Lane extraction for loads, little-endian byte order
    always_comb begin
        rd_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: rd_byte = memoryOutData[7:0];
            2'd1: rd_byte = memoryOutData[15:8];
            2'd2: rd_byte = memoryOutData[23:16];
            2'd3: rd_byte = memoryOutData[31:24];
        endcase
        rd_half = addr_q[1] ? memoryOutData[31:16] : memoryOutData[15:0];
        unique case (size_q)
            2'b00:   load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_val = memoryOutData;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        sext_d  = sext_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        unique case (state_q)
            IDLE: if (req) begin
                addr_d  = addr;
                wdata_d = wdata;
                size_d  = size;
                we_d    = we;
                sext_d  = sign_ext;
                if (bad)
                    state_d = ERR;
                else if (we && size == 2'b10)
                    state_d = WR;
                else
                    state_d = RD;
            end
            RD: begin
                if (we_q) begin
                    merge_d = memoryOutData;
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = DONE;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    assign rdata         = rdata_q;
    assign ready         = (state_q == DONE) || (state_q == ERR);
    assign err           = (state_q == ERR);
    assign busy          = (state_q != IDLE);
    assign memoryRead    = (state_q == RD);
    assign memoryWrite   = (state_q == WR);
    assign memoryAddress = {addr_q[31:2], 2'b00};
    assign memoryWriteData = (state_q != WR) ? 32'h0
                           : (size_q == 2'b10) ? wdata_q : merged;

endmodule
